// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words, writes them to
// instruction memory, verifies a trailing XOR checksum and stalls the CPU until done.
module imem_loader #(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [15:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  function automatic logic [7:0] chk_upd(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  hi_q, hi_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  // armed_q blocks a start sampled on the first edge after reset release
  logic        armed_q;
  logic        xfer_s;
  logic [8:0]  idx_inc_s;

  assign xfer_s    = in_valid && ready_q;
  assign idx_inc_s = idx_q + 9'd1;

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start && armed_q) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = 9'd0;
          chk_d   = 8'h00;
          hold_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN: begin
        if (xfer_s) begin
          cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          chk_d   = in_data;
          state_d = S_HI;
        end else begin
          state_d = state_q;
        end
      end
      S_HI: begin
        if (xfer_s) begin
          hi_d    = in_data;
          chk_d   = chk_upd(chk_q, in_data);
          state_d = S_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_LO: begin
        if (xfer_s) begin
          wdata_d = {hi_q, in_data};
          addr_d  = START_ADDR + idx_q[7:0];
          we_d    = 1'b1;
          chk_d   = chk_upd(chk_q, in_data);
          idx_d   = idx_inc_s;
          state_d = (idx_inc_s == cnt_q) ? S_CHK : S_HI;
        end else begin
          state_d = state_q;
        end
      end
      S_CHK: begin
        if (xfer_s) begin
          if (in_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
              (state_d == S_LO)  || (state_d == S_CHK);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 9'd0;
      idx_q   <= 9'd0;
      chk_q   <= 8'h00;
      hi_q    <= 8'h00;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 16'h0000;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      armed_q <= 1'b1;
    end
  end

  assign in_ready = ready_q;
  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
